// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory bundle interface: upstream valid/ready from execute, flush,
// and downstream valid/ready toward the data-memory stage.
interface ex_mem_stage_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
);
    // Handshake: a bundle moves on any rising edge where valid and ready are both 1;
    // valid must not depend on ready, and in_ready never depends on out_ready.
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      alu_result;
    logic                  zero_flag;
    logic [WIDTH-1:0]      write_data;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  branch;
    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_alu_result;
    logic                  out_zero;
    logic [WIDTH-1:0]      out_write_data;
    logic [REG_ADDR_W-1:0] out_write_reg;
    logic                  out_reg_write;
    logic                  out_mem_write;
    logic                  out_mem_to_reg;
    logic                  out_branch;
    logic                  out_pc_src;

    modport slave (
        input  in_valid, alu_result, zero_flag, write_data, write_reg,
               reg_write, mem_write, mem_to_reg, branch, flush, out_ready,
        output in_ready, out_valid, out_alu_result, out_zero, out_write_data,
               out_write_reg, out_reg_write, out_mem_write, out_mem_to_reg,
               out_branch, out_pc_src
    );

    modport master (
        output in_valid, alu_result, zero_flag, write_data, write_reg,
               reg_write, mem_write, mem_to_reg, branch, flush, out_ready,
        input  in_ready, out_valid, out_alu_result, out_zero, out_write_data,
               out_write_reg, out_reg_write, out_mem_write, out_mem_to_reg,
               out_branch, out_pc_src
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: main register M feeds the memory stage, skid register S
// absorbs one bundle of backpressure. Optional stall counter: EX_MEM_STALL_COUNT_EN.
module ex_mem_stage #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic clk,
    input  logic reset,
    ex_mem_stage_if.slave bus
`ifdef EX_MEM_STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);
    typedef struct packed {
        logic [WIDTH-1:0]      alu_result;
        logic                  zero;
        logic [WIDTH-1:0]      write_data;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  branch;
    } bundle_t;

    bundle_t w_in;
    bundle_t r_m;
    bundle_t r_s;
    logic    r_m_valid;
    logic    r_s_valid;
    logic    w_accept;
    logic    w_release;

    always_comb begin
        w_in            = '0;
        w_in.alu_result = bus.alu_result;
        w_in.zero       = bus.zero_flag;
        w_in.write_data = bus.write_data;
        w_in.write_reg  = bus.write_reg;
        w_in.reg_write  = bus.reg_write;
        w_in.mem_write  = bus.mem_write;
        w_in.mem_to_reg = bus.mem_to_reg;
        w_in.branch     = bus.branch;
    end

    // Ready depends only on skid occupancy, so no combinational path from out_ready.
    assign bus.in_ready = !r_s_valid && !reset;
    assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_release    = r_m_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
            r_s       <= '0;
        end else if (bus.flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (r_s_valid) begin
            if (w_release) begin
                r_m       <= r_s;
                r_s_valid <= 1'b0;
            end
        end else if (!r_m_valid || w_release) begin
            if (w_accept) begin
                r_m <= w_in;
            end
            r_m_valid <= w_accept;
        end else if (w_accept) begin
            r_s       <= w_in;
            r_s_valid <= 1'b1;
        end
    end

    // Data fields hold when invalid; control bits are gated so nothing stale acts downstream.
    assign bus.out_valid      = r_m_valid;
    assign bus.out_alu_result = r_m.alu_result;
    assign bus.out_zero       = r_m.zero;
    assign bus.out_write_data = r_m.write_data;
    assign bus.out_write_reg  = r_m.write_reg;
    assign bus.out_reg_write  = r_m_valid && r_m.reg_write;
    assign bus.out_mem_write  = r_m_valid && r_m.mem_write;
    assign bus.out_mem_to_reg = r_m_valid && r_m.mem_to_reg;
    assign bus.out_branch     = r_m_valid && r_m.branch;
    assign bus.out_pc_src     = r_m_valid && r_m.branch && r_m.zero;

`ifdef EX_MEM_STALL_COUNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (r_m_valid && !bus.out_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a 2-deep FIFO reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_mem_stage;
    logic clk;
    logic rst;

    ex_mem_stage_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

`ifdef EX_MEM_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    ex_mem_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
`ifdef EX_MEM_STALL_COUNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        rw;
        logic        mw;
        logic        mtr;
        logic        br;
    } bundle_t;

    bundle_t exp_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    bit      chk_en = 0;
`ifdef EX_MEM_STALL_COUNT_EN
    logic [31:0] exp_stall = '0;
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a FIFO of at most two bundles ----------------
    always @(posedge clk) begin
        bundle_t b;
        bit acc;
        bit rel;
        acc = bus.in_valid && !rst && (exp_q.size() < 2) && !bus.flush;
        rel = (exp_q.size() > 0) && bus.out_ready;
        if (rst) begin
            exp_q.delete();
`ifdef EX_MEM_STALL_COUNT_EN
            exp_stall = '0;
`endif
        end else begin
`ifdef EX_MEM_STALL_COUNT_EN
            if ((exp_q.size() > 0) && !bus.out_ready && exp_stall != 32'hFFFF_FFFF)
                exp_stall = exp_stall + 1;
`endif
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (rel) void'(exp_q.pop_front());
                if (acc) begin
                    b.alu = bus.alu_result;  b.zero = bus.zero_flag;
                    b.wd  = bus.write_data;  b.wr   = bus.write_reg;
                    b.rw  = bus.reg_write;   b.mw   = bus.mem_write;
                    b.mtr = bus.mem_to_reg;  b.br   = bus.branch;
                    exp_q.push_back(b);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bundle_t e;
        if (chk_en) begin
            chk("in_ready", bus.in_ready, !rst && (exp_q.size() < 2));
            chk("out_valid", bus.out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("out_alu_result", bus.out_alu_result, e.alu);
                chk("out_zero", bus.out_zero, e.zero);
                chk("out_write_data", bus.out_write_data, e.wd);
                chk("out_write_reg", bus.out_write_reg, e.wr);
                chk("out_reg_write", bus.out_reg_write, e.rw);
                chk("out_mem_write", bus.out_mem_write, e.mw);
                chk("out_mem_to_reg", bus.out_mem_to_reg, e.mtr);
                chk("out_branch", bus.out_branch, e.br);
                chk("out_pc_src", bus.out_pc_src, e.br & e.zero);
            end else begin
                chk("idle_ctrl", {bus.out_reg_write, bus.out_mem_write, bus.out_mem_to_reg,
                                  bus.out_branch, bus.out_pc_src}, 5'b0);
            end
`ifdef EX_MEM_STALL_COUNT_EN
            chk("stall_count", stall_count, exp_stall);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] alu, input logic [4:0] wr, input logic rw,
                          input logic mw, input logic br, input logic z);
        bus.in_valid   = 1'b1;
        bus.alu_result = alu;
        bus.write_data = $urandom;
        bus.write_reg  = wr;
        bus.reg_write  = rw;
        bus.mem_write  = mw;
        bus.mem_to_reg = 1'b0;
        bus.branch     = br;
        bus.zero_flag  = z;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        set_in(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        step();
        chk_en = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_alu_result", bus.out_alu_result, 32'h0);
        chk("rst_out_write_data", bus.out_write_data, 32'h0);
        chk("rst_out_write_reg", bus.out_write_reg, 5'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);

        // Single bundle, latency one cycle
        bus.out_ready = 1'b1;
        set_in(32'h0000_0010, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_alu", bus.out_alu_result, 32'h10);
        chk("single_wr", bus.out_write_reg, 5'd8);
        chk("single_rw", bus.out_reg_write, 1'b1);
        chk("single_in_ready", bus.in_ready, 1'b1);
        step();

        // Back-to-back stream 1..4
        set_in(32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) set_in(32'(i + 1), 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            else idle();
            @(negedge clk);
            chk("stream_valid", bus.out_valid, 1'b1);
            chk("stream_alu", bus.out_alu_result, 32'(i));
            step();
        end

        // Backpressure: A in M, B in S
        bus.out_ready = 1'b0;
        set_in(32'hA, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_in(32'hB, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("bp_alu_a", bus.out_alu_result, 32'hA);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        step();
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_alu_b", bus.out_alu_result, 32'hB);
        chk("bp_ready_back", bus.in_ready, 1'b1);
        step();
        @(negedge clk);
        chk("bp_drained", bus.out_valid, 1'b0);

        // Flush with M and S full
        bus.out_ready = 1'b0;
        set_in(32'h100, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(32'h200, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(32'h300, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_mem_write", bus.out_mem_write, 1'b0);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("flush_dropped", bus.out_valid, 1'b0);

        // Branch resolution
        set_in(32'h20, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("pc_src_taken", bus.out_pc_src, 1'b1);
        step();
        set_in(32'h24, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("pc_src_not_taken", bus.out_pc_src, 1'b0);
        step();

`ifdef EX_MEM_STALL_COUNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        set_in(32'h55, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        repeat (7) step();
        @(negedge clk);
        chk("stall_seven", stall_count, 32'd7);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("stall_reset", stall_count, 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
`endif

        // Randomized traffic with occasional flush and reset
        repeat (3000) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            set_in($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom_range(0, 3) == 0));
            bus.mem_to_reg = 1'($urandom);
            bus.in_valid   = ($urandom_range(0, 9) < 7);
            step();
        end

        rst = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage for the MIPS datapath.
- Sits directly downstream of the ALU. Registers the ALU result, zero flag, store data, destination register and memory/writeback control bits.
- Presents these to the data-memory stage through a valid/ready handshake.
- A 2-entry skid buffer absorbs memory-stage backpressure without a combinational ready path back into execute.

Parameters:
- WIDTH, 32, datapath width of alu_result and write_data.
- REG_ADDR_W, 5, width of the destination register index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  execute stage presents a valid bundle.
- in_ready  output  1  stage can accept a bundle this cycle.
- alu_result  input  WIDTH  ALU result.
- zero_flag  input  1  ALU zero flag.
- write_data  input  WIDTH  store data (rt value).
- write_reg  input  REG_ADDR_W  destination register index.
- reg_write  input  1  writeback enable.
- mem_write  input  1  data-memory write enable.
- mem_to_reg  input  1  writeback source select.
- branch  input  1  instruction is a branch.
- flush  input  1  discard all held bundles (branch taken / exception).
- out_valid  output  1  bundle available to memory stage.
- out_ready  input  1  memory stage accepts bundle.
- out_alu_result  output  WIDTH  registered alu_result.
- out_zero  output  1  registered zero_flag.
- out_write_data  output  WIDTH  registered write_data.
- out_write_reg  output  REG_ADDR_W  registered write_reg.
- out_reg_write, out_mem_write, out_mem_to_reg, out_branch  output  1 each  registered control bits.
- out_pc_src  output  1  out_valid & out_branch & out_zero (combinational from main register).

Behaviour:
- Storage: main register M (drives all out_* ports) plus skid register S, each with its own valid bit.
- out_valid = M.valid. in_ready = !S.valid & !reset. in_ready never depends combinationally on out_ready.
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Cases, evaluated each cycle:
  - M empty, accept: load M; out_valid=1 next cycle. Latency 1 cycle.
  - M full, release & accept, S empty: M <= input.
  - M full, !release & accept: S <= input; in_ready=0 next cycle.
  - S full & release: M <= S, S cleared. Input not accepted that cycle because in_ready=0.
  - Release & !accept with S empty: M.valid cleared.
- Order strictly preserved. Sustained throughput 1 bundle/cycle when out_ready=1.
- Control bits and out_pc_src are masked to 0 whenever the corresponding valid bit is 0, so no stale mem_write or reg_write reaches downstream.
- Data fields hold their last value when invalid. They are not required to be zero.
- Flush:
  - M.valid and S.valid cleared next cycle.
  - A bundle offered with in_valid in the same cycle as flush is dropped.
  - A release in the same cycle as flush still counts as a completed transfer downstream.
  - in_ready=1 in the cycle after flush.
- Reset: all valid bits 0. All out_* ports 0, including data fields. in_ready=0 while reset is high and 1 in the first cycle after reset deasserts. Reset mid-transfer discards M and S contents; no partial bundle survives.
- Reset has priority over flush; flush has priority over accept.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: EX_MEM_STALL_COUNT_EN.
- Defined: adds output port stall_count [31:0]. The counter increments each cycle with out_valid=1 & out_ready=0, saturates at 32'hFFFFFFFF, and is cleared by reset. Flush does not clear it.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid=1 with alu_result=32'h0000_0010, write_reg=5'd8, reg_write=1, out_ready=1 -> out_valid=1 one cycle later with the same values; in_ready stays 1.
- Stream 4 bundles (alu_result 1,2,3,4) back-to-back, out_ready=1 -> outputs 1,2,3,4 on consecutive cycles; no bubbles.
- out_ready=0, offer bundles A=32'hA, B=32'hB -> A held in M, B in S, in_ready=0. Raise out_ready -> A then B emerge in order; in_ready returns to 1 after B moves to M.
- M and S full (mem_write=1), assert flush -> next cycle out_valid=0, out_mem_write=0, in_ready=1; the bundle offered during the flush cycle never appears.
- branch=1, zero_flag=1, accepted -> out_pc_src=1 while out_valid. With zero_flag=0 -> out_pc_src=0.
- Under EX_MEM_STALL_COUNT_EN: hold out_ready=0 for 7 cycles with out_valid=1 -> stall_count=7. Then reset -> stall_count=0.
